// File: rtl/fifo_rd_streamer_if.sv
// Read-port, stream and status signals connecting fifo_rd_streamer to its FIFO and its consumer.
interface fifo_rd_streamer_if #(
    parameter int unsigned G_WIDTH = 8,
    parameter int unsigned G_DEPTH = 10
);
    logic               i_en;
    logic               i_empty;
    logic [G_DEPTH:0]   i_fill_level;
    logic               i_underflow;
    logic [G_WIDTH-1:0] i_data;
    logic               o_rd;
    logic               o_valid;
    logic [G_WIDTH-1:0] o_data;
    logic               i_ready;
    logic               o_busy;
    logic               o_err_uflow;

    modport master (
        input  i_en, i_empty, i_fill_level, i_underflow, i_data, i_ready,
        output o_rd, o_valid, o_data, o_busy, o_err_uflow
    );

    modport slave (
        output i_en, i_empty, i_fill_level, i_underflow, i_data, i_ready,
        input  o_rd, o_valid, o_data, o_busy, o_err_uflow
    );
endinterface

// File: rtl/fifo_rd_streamer.sv
// FIFO read-side master: pops a sync FIFO and re-presents words as a valid/ready stream via a 2-entry buffer.
// Optional FIFO_RD_STREAMER_STATS_EN adds o_word_cnt / o_stall_cnt counters.
module fifo_rd_streamer #(
    parameter int unsigned G_WIDTH = 8,
    parameter int unsigned G_DEPTH = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    fifo_rd_streamer_if.master   bus
`ifdef FIFO_RD_STREAMER_STATS_EN
    ,
    output logic [31:0]          o_word_cnt,
    output logic [31:0]          o_stall_cnt
`endif
);
    localparam int unsigned FILL_W = G_DEPTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_e;

    state_e             state_q, state_d;
    logic [1:0]         occ_q, occ_d;
    logic               inflight_q, inflight_d;
    logic [G_WIDTH-1:0] buf0_q, buf0_d;
    logic [G_WIDTH-1:0] buf1_q, buf1_d;
    logic               err_q, err_d;

    logic               pop_c;
    logic               rd_c;
    logic               fifo_empty_c;
    logic [1:0]         lvl_c;

    // A zero fill level is treated as empty too, so a pop is never issued without data behind it.
    assign fifo_empty_c = bus.i_empty | (bus.i_fill_level == FILL_W'(0));
    assign pop_c        = (occ_q != 2'd0) & bus.i_ready;
    assign lvl_c        = occ_q + {1'b0, inflight_q};
    assign rd_c         = (state_q == S_RUN) & ~fifo_empty_c
                        & (lvl_c < (pop_c ? 2'd3 : 2'd2));

    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        inflight_d = rd_c;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        err_d      = err_q | (rd_c & bus.i_empty) | bus.i_underflow;

        case (state_q)
            S_IDLE:  if (bus.i_en) state_d = S_RUN;
            S_RUN:   if (!bus.i_en) state_d = S_STOP;
            S_STOP: begin
                if (bus.i_en)                                 state_d = S_RUN;
                else if ((occ_q == 2'd0) && !inflight_q)      state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Buffer entry 0 is always the head; writes land behind the current tail.
        case ({inflight_q, pop_c})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = bus.i_data;
                else               buf1_d = bus.i_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = bus.i_data;
                end else begin
                    buf0_d = bus.i_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            err_q      <= err_d;
        end
    end

    assign bus.o_rd        = rd_c;
    assign bus.o_valid     = (occ_q != 2'd0);
    assign bus.o_data      = buf0_q;
    assign bus.o_busy      = (state_q != S_IDLE) | (occ_q != 2'd0) | inflight_q;
    assign bus.o_err_uflow = err_q;

`ifdef FIFO_RD_STREAMER_STATS_EN
    logic [31:0] word_cnt_q;
    logic [31:0] stall_cnt_q;

    // Word count wraps; stall count saturates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_cnt_q  <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (pop_c) word_cnt_q <= word_cnt_q + 32'd1;
            if ((occ_q != 2'd0) && !bus.i_ready && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_word_cnt  = word_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench for fifo_rd_streamer: a queue-based FIFO model feeds the DUT, a monitor checks the stream.
module tb_fifo_rd_streamer;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 10;
    localparam int unsigned FW = D + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_rd_streamer_if #(.G_WIDTH(W), .G_DEPTH(D)) bus ();

`ifdef FIFO_RD_STREAMER_STATS_EN
    logic [31:0] word_cnt;
    logic [31:0] stall_cnt;
`endif

    fifo_rd_streamer #(.G_WIDTH(W), .G_DEPTH(D)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
`ifdef FIFO_RD_STREAMER_STATS_EN
        ,
        .o_word_cnt  (word_cnt),
        .o_stall_cnt (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int           rd_log[$];
    int           xfer_q[$];
    int           n_xfer  = 0;
    int           n_stall = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // One clock of the FIFO model: o_rd seen before the edge pops a word that appears as i_data after it.
    task automatic tick();
        logic rd;
        @(negedge clk);
        rd = bus.o_rd;
        @(posedge clk);
        #1;
        if (rd) begin
            rd_log.push_back(cyc);
            if (fifo_q.size() > 0) bus.i_data = fifo_q.pop_front();
        end
        bus.i_empty      = (fifo_q.size() == 0);
        bus.i_fill_level = FW'(fifo_q.size());
        cyc++;
    endtask

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        bus.i_empty      = 1'b0;
        bus.i_fill_level = FW'(fifo_q.size());
    endtask

    task automatic drain(input string nm, input int budget);
        bus.i_en    = 1'b1;
        bus.i_ready = 1'b1;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic settle_idle(input string nm);
        bus.i_en = 1'b0;
        for (int i = 0; i < 20 && bus.o_busy; i++) tick();
        chk(nm, 64'(bus.o_busy), 64'd0);
    endtask

    // Monitor: pops the expected queue on every handshake and enforces no-retraction.
    initial begin : monitor
        logic         prev_stall;
        logic [W-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                n_xfer     = 0;
                n_stall    = 0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(bus.o_valid), 64'd1);
                    chk("hold_data", 64'(bus.o_data), 64'(prev_data));
                end
                if (bus.o_rd) chk("rd_when_empty", 64'(bus.i_empty), 64'd0);
                if (bus.o_valid && bus.i_ready) begin
                    n_xfer++;
                    xfer_q.push_back(cyc);
                    if (exp_q.size() == 0) chk("unexpected_word", 64'(bus.o_data), 64'hFFFF);
                    else                   chk("stream_data", 64'(bus.o_data), 64'(exp_q.pop_front()));
                end
                if (bus.o_valid && !bus.i_ready) n_stall++;
                prev_stall = bus.o_valid & ~bus.i_ready;
                prev_data  = bus.o_data;
            end
        end
    end

    initial begin
        bus.i_en = 1'b0; bus.i_ready = 1'b0; bus.i_empty = 1'b1;
        bus.i_fill_level = '0; bus.i_underflow = 1'b0; bus.i_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(bus.o_valid), 64'd0);
        chk("reset_rd", 64'(bus.o_rd), 64'd0);
        chk("reset_busy", 64'(bus.o_busy), 64'd0);
        chk("reset_data", 64'(bus.o_data), 64'd0);
        chk("reset_err", 64'(bus.o_err_uflow), 64'd0);
        rst_n = 1'b1;

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) push(W'(i));
        rd_log.delete(); xfer_q.delete();
        bus.i_ready = 1'b1; bus.i_en = 1'b1;
        repeat (14) tick();
        chk("t2_rd_count", 64'(rd_log.size()), 64'd8);
        chk("t2_xfer_count", 64'(xfer_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < rd_log.size() && i < xfer_q.size(); i++) begin
            chk("t2_rd_cycle", 64'(rd_log[i]), 64'(rd_log[0] + i));
            chk("t2_valid_cycle", 64'(xfer_q[i]), 64'(rd_log[0] + 2 + i));
        end
        settle_idle("t2_idle");

        // Back-pressure: only two pops fit before the buffer is full.
        bus.i_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(W'(i));
        rd_log.delete();
        bus.i_en = 1'b1;
        repeat (8) tick();
        chk("t3_rd_pulses", 64'(rd_log.size()), 64'd2);
        chk("t3_valid", 64'(bus.o_valid), 64'd1);
        chk("t3_head", 64'(bus.o_data), 64'h01);
        drain("t3_drain", 50);
        chk("t3_fifo_empty", 64'(fifo_q.size()), 64'd0);
        settle_idle("t3_idle");

        // Empty boundary: one word in the FIFO gives exactly one pop.
        rd_log.delete();
        push(8'hA5);
        bus.i_en = 1'b1; bus.i_ready = 1'b1;
        repeat (6) tick();
        chk("t4_single_rd", 64'(rd_log.size()), 64'd1);
        chk("t4_delivered", 64'(exp_q.size()), 64'd0);
        chk("t4_no_err", 64'(bus.o_err_uflow), 64'd0);
        settle_idle("t4_idle");

        // Stop with one word buffered and one in flight; both must drain.
        bus.i_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(W'(8'h10 + i));
        rd_log.delete();
        bus.i_en = 1'b1;
        for (int i = 0; i < 10 && rd_log.size() < 2; i++) tick();
        bus.i_en = 1'b0;
        repeat (3) tick();
        chk("t5_rd_stopped", 64'(rd_log.size()), 64'd2);
        bus.i_ready = 1'b1;
        for (int i = 0; i < 20 && bus.o_busy; i++) tick();
        chk("t5_busy", 64'(bus.o_busy), 64'd0);
        chk("t5_delivered2", 64'(exp_q.size()), 64'd3);
        chk("t5_valid", 64'(bus.o_valid), 64'd0);
        repeat (3) tick();
        chk("t5_no_more_rd", 64'(rd_log.size()), 64'd2);
        drain("t5_resume", 50);
        settle_idle("t5_idle");

        // Randomised pushes, back-pressure and enable toggling.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 1000) push(W'($urandom));
            bus.i_ready = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 49) == 0) bus.i_en = ~bus.i_en;
            tick();
        end
        drain("rand_drain", 3000);
        settle_idle("rand_idle");

        // Underflow flag is sticky.
        bus.i_underflow = 1'b1;
        tick();
        bus.i_underflow = 1'b0;
        chk("t6_err_set", 64'(bus.o_err_uflow), 64'd1);
        repeat (5) tick();
        chk("t6_err_sticky", 64'(bus.o_err_uflow), 64'd1);
`ifdef FIFO_RD_STREAMER_STATS_EN
        chk("t6_word_cnt", 64'(word_cnt), 64'(n_xfer));
        chk("t6_stall_cnt", 64'(stall_cnt), 64'(n_stall));
`endif

        // Asynchronous reset with the buffer full.
        bus.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(W'(8'h40 + i));
        bus.i_en = 1'b1;
        repeat (6) tick();
        chk("t1_pre_valid", 64'(bus.o_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_valid", 64'(bus.o_valid), 64'd0);
        chk("t1_rd", 64'(bus.o_rd), 64'd0);
        chk("t1_busy", 64'(bus.o_busy), 64'd0);
        chk("t1_err_clr", 64'(bus.o_err_uflow), 64'd0);
        fifo_q.delete(); exp_q.delete();
        bus.i_en = 1'b0; bus.i_empty = 1'b1; bus.i_fill_level = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef FIFO_RD_STREAMER_STATS_EN
        chk("t1_word_cnt", 64'(word_cnt), 64'd0);
        chk("t1_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        for (int i = 0; i < 3; i++) push(W'(8'hC0 + i));
        drain("t1_after_reset", 50);
        settle_idle("t1_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
